// File: rtl/urv_mem_arbiter.sv
// urv_mem_arbiter: shares one single-port synchronous RAM between the urv_cpu
// fetch port (im_*) and data port (dm_*), and routes data accesses at or above
// IO_BASE to a simple I/O bus.
// Optional build macro URV_MEM_ARB_RR_EN: round-robin between a pending data
// access and instruction fetch. Undefined: data always wins.
module urv_mem_arbiter #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] IO_BASE    = 32'h00100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           im_addr_i,
  output logic [31:0]           im_data_o,
  output logic                  im_valid_o,
  input  logic [31:0]           dm_addr_i,
  input  logic [31:0]           dm_data_s_i,
  input  logic [3:0]            dm_data_select_i,
  input  logic                  dm_store_i,
  input  logic                  dm_load_i,
  output logic [31:0]           dm_data_l_o,
  output logic                  dm_load_done_o,
  output logic                  dm_store_done_o,
  output logic                  dm_ready_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  io_rd_o,
  output logic                  io_wr_o,
  output logic [31:0]           io_addr_o,
  output logic [31:0]           io_wdata_o,
  output logic [3:0]            io_sel_o,
  input  logic [31:0]           io_rdata_i,
  input  logic                  io_ready_i
);

  // Handshake: a data request is taken in any cycle where dm_ready_o=1 and
  // dm_load_i or dm_store_i is high; completion is a one-cycle done pulse.
  typedef enum logic [1:0] {S_IDLE, S_DPEND, S_IO_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            store_q, store_d;
  logic            fetch_q, fetch_d;     // a fetch was issued last cycle
  logic            ld_done_q, ld_done_d; // a RAM load was issued last cycle
`ifdef URV_MEM_ARB_RR_EN
  logic            rr_q, rr_d;           // last contested RAM grant went to data
`endif

  logic                  ready_c, dm_req_c, io_tgt_c, data_grant_c;
  logic                  ram_en_c, st_done_c, io_ld_done_c;
  logic [3:0]            ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [31:0]           ram_wdata_c;
  logic                  io_act_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{im_addr_i[31:ADDR_WIDTH+2], im_addr_i[1:0]};

  // Next-state, request capture and RAM port arbitration
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    store_d      = store_q;
    fetch_d      = 1'b0;
    ld_done_d    = 1'b0;
`ifdef URV_MEM_ARB_RR_EN
    rr_d         = rr_q;
`endif
    ready_c      = (state_q == S_IDLE) && !ld_done_q;
    dm_req_c     = ready_c && (dm_load_i || dm_store_i);
    io_tgt_c     = (addr_q >= IO_BASE);
    data_grant_c = 1'b0;
    ram_en_c     = 1'b0;
    ram_we_c     = 4'b0000;
    ram_addr_c   = im_addr_i[ADDR_WIDTH+1:2];
    ram_wdata_c  = 32'h0;
    st_done_c    = 1'b0;
    io_ld_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ram_en_c = 1'b1;
        fetch_d  = 1'b1;
        if (dm_req_c) begin
          addr_d  = dm_addr_i;
          wdata_d = dm_data_s_i;
          sel_d   = dm_data_select_i;
          store_d = dm_store_i; // store wins when both are requested
          state_d = S_DPEND;
        end
      end
      S_DPEND: begin
        if (io_tgt_c) begin
          // RAM is free while the I/O access runs, so keep fetching
          ram_en_c = 1'b1;
          fetch_d  = 1'b1;
          state_d  = S_IO_WAIT;
        end else begin
          data_grant_c = 1'b1;
`ifdef URV_MEM_ARB_RR_EN
          if (rr_q) begin
            data_grant_c = 1'b0;
            ram_en_c     = 1'b1;
            fetch_d      = 1'b1;
            rr_d         = 1'b0;
          end else begin
            rr_d = 1'b1;
          end
`endif
          if (data_grant_c) begin
            ram_en_c   = 1'b1;
            ram_addr_c = addr_q[ADDR_WIDTH+1:2];
            state_d    = S_IDLE;
            if (store_q) begin
              ram_we_c    = sel_q;
              ram_wdata_c = wdata_q;
              st_done_c   = 1'b1;
            end else begin
              ld_done_d = 1'b1;
            end
          end
        end
      end
      S_IO_WAIT: begin
        ram_en_c = 1'b1;
        fetch_d  = 1'b1;
        if (io_ready_i) begin
          state_d      = S_IDLE;
          st_done_c    = store_q;
          io_ld_done_c = !store_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      sel_q     <= 4'b0000;
      store_q   <= 1'b0;
      fetch_q   <= 1'b0;
      ld_done_q <= 1'b0;
`ifdef URV_MEM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      store_q   <= store_d;
      fetch_q   <= fetch_d;
      ld_done_q <= ld_done_d;
`ifdef URV_MEM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // Every output is forced to zero while reset is asserted
  assign io_act_c        = (state_q == S_IO_WAIT);
  assign ram_en_o        = !rst_i && ram_en_c;
  assign ram_we_o        = rst_i ? 4'b0000 : ram_we_c;
  assign ram_addr_o      = rst_i ? '0 : ram_addr_c;
  assign ram_wdata_o     = rst_i ? 32'h0 : ram_wdata_c;
  assign im_valid_o      = !rst_i && fetch_q;
  assign im_data_o       = (!rst_i && fetch_q) ? ram_rdata_i : 32'h0;
  assign dm_ready_o      = !rst_i && ready_c;
  assign dm_store_done_o = !rst_i && st_done_c;
  assign dm_load_done_o  = !rst_i && (ld_done_q || io_ld_done_c);
  assign dm_data_l_o     = rst_i        ? 32'h0 :
                           ld_done_q    ? ram_rdata_i :
                           io_ld_done_c ? io_rdata_i : 32'h0;
  assign io_rd_o         = !rst_i && io_act_c && !store_q;
  assign io_wr_o         = !rst_i && io_act_c && store_q;
  assign io_addr_o       = (!rst_i && io_act_c) ? addr_q : 32'h0;
  assign io_wdata_o      = (!rst_i && io_act_c) ? wdata_q : 32'h0;
  assign io_sel_o        = (!rst_i && io_act_c) ? sel_q : 4'b0000;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter with a behavioural synchronous RAM.
module tb_urv_mem_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   im_addr, im_data;
  logic          im_valid;
  logic [31:0]   dm_addr, dm_data_s, dm_data_l;
  logic [3:0]    dm_sel;
  logic          dm_store, dm_load, dm_load_done, dm_store_done, dm_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          io_rd, io_wr, io_ready;
  logic [31:0]   io_addr, io_wdata, io_rdata;
  logic [3:0]    io_sel;

  logic [31:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  // Clock and reset block
  always #5 clk = ~clk;

  urv_mem_arbiter #(.ADDR_WIDTH(AW), .IO_BASE(32'h00100000)) dut (
    .clk_i(clk), .rst_i(rst),
    .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_store_i(dm_store), .dm_load_i(dm_load), .dm_data_l_o(dm_data_l),
    .dm_load_done_o(dm_load_done), .dm_store_done_o(dm_store_done),
    .dm_ready_o(dm_ready),
    .ram_addr_o(ram_addr), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .io_rd_o(io_rd), .io_wr_o(io_wr), .io_addr_o(io_addr),
    .io_wdata_o(io_wdata), .io_sel_o(io_sel), .io_rdata_i(io_rdata),
    .io_ready_i(io_ready)
  );

  // Synchronous single-port RAM model, one cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle; inputs are driven 2 time units after posedge
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_dm(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    dm_load   = ld;
    dm_store  = st;
    dm_addr   = a;
    dm_data_s = d;
    dm_sel    = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fw [4];
    int lat;
    int exp_lat;
    fw[0] = 32'h13; fw[1] = 32'h93; fw[2] = 32'h113; fw[3] = 32'h193;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = fw[i];
    mem[16] = 32'h11223344;
    ram_rdata = 32'h0;
    rst = 1'b1; im_addr = 32'h0; io_rdata = 32'h0; io_ready = 1'b0;
    drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset
    next(); #1;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ready", dm_ready, 0);
    chk("rst_im_valid", im_valid, 0);
    next(); rst = 1'b0; #1;
    chk("rel_ready", dm_ready, 1);
    chk("rel_ram_en", ram_en, 1);

    // Fetch stream
    next(); im_addr = 32'h0; #1;
    chk("fetch_addr0", ram_addr, 0);
    chk("fetch_we0", ram_we, 0);
    for (int i = 0; i < 4; i++) begin
      next(); im_addr = (i < 3) ? 32'(4*(i+1)) : 32'h0; #1;
      chk("fetch_valid", im_valid, 1);
      chk("fetch_data", im_data, fw[i]);
    end

    // Store then load at 0x40
    next(); drive_dm(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0110); #1;
    chk("st_ready", dm_ready, 1);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("st_done", dm_store_done, 1);
    chk("st_we", ram_we, 4'b0110);
    chk("st_addr", ram_addr, 32'h10);
    chk("st_wdata", ram_wdata, 32'hDEADBEEF);
    chk("st_busy", dm_ready, 0);
    next(); drive_dm(1'b1, 1'b0, 32'h40, 32'h0, 4'h0); #1;
    chk("st_im_gap", im_valid, 0);
    chk("st_ready_again", dm_ready, 1);
    chk("st_done_pulse", dm_store_done, 0);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("ld_en", ram_en, 1);
    chk("ld_we", ram_we, 0);
    chk("ld_addr", ram_addr, 32'h10);
    chk("ld_early", dm_load_done, 0);
    next(); #1;
    chk("ld_done", dm_load_done, 1);
    chk("ld_data", dm_data_l, 32'h11ADBE44);
    chk("ld_im_gap", im_valid, 0);
    chk("ld_busy", dm_ready, 0);
    next(); #1;
    chk("ld_ready_again", dm_ready, 1);
    chk("ld_done_pulse", dm_load_done, 0);

    // Wrap: 0x10000 maps to word 0
    drive_dm(1'b0, 1'b1, 32'h10000, 32'hA5A5A5A5, 4'b1111);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("wrap_addr", ram_addr, 0);
    chk("wrap_we", ram_we, 4'b1111);
    next(); #1;
    chk("wrap_mem0", mem[0], 32'hA5A5A5A5);

    // I/O store with io_ready delayed by 3 cycles
    drive_dm(1'b0, 1'b1, 32'h00100000, 32'h41, 4'b0001);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("io_wr_dpend", io_wr, 0);
    chk("io_fetch_dpend", ram_en, 1);
    for (int k = 0; k < 4; k++) begin
      next(); io_ready = (k == 3); #1;
      chk("io_wr_held", io_wr, 1);
      chk("io_addr", io_addr, 32'h00100000);
      chk("io_wdata", io_wdata, 32'h41);
      chk("io_sel", io_sel, 4'b0001);
      chk("io_st_done", dm_store_done, (k == 3) ? 1 : 0);
      chk("io_fetch_on", im_valid, 1);
    end
    next(); io_ready = 1'b0; #1;
    chk("io_wr_off", io_wr, 0);
    chk("io_ready_again", dm_ready, 1);

    // I/O store to the test-complete register, device ready at once
    drive_dm(1'b0, 1'b1, 32'h00100004, 32'h1, 4'b1111);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); io_ready = 1'b1; #1;
    next(); #1;
    chk("io2_wr", io_wr, 1);
    chk("io2_addr", io_addr, 32'h00100004);
    chk("io2_done", dm_store_done, 1);
    next(); io_ready = 1'b0; #1;

    // I/O load
    drive_dm(1'b1, 1'b0, 32'h00100000, 32'h0, 4'h0); io_rdata = 32'h5A; io_ready = 1'b1;
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("iold_early", dm_load_done, 0);
    next(); #1;
    chk("iold_rd", io_rd, 1);
    chk("iold_done", dm_load_done, 1);
    chk("iold_data", dm_data_l, 32'h5A);
    next(); io_ready = 1'b0; #1;

    // Reset in the issue cycle of a load
    drive_dm(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); rst = 1'b1; #1;
    chk("rstld_en", ram_en, 0);
    next(); #1;
    chk("rstld_done", dm_load_done, 0);
    chk("rstld_ready", dm_ready, 0);
    chk("rstld_ram_en", ram_en, 0);
    next(); rst = 1'b0; #1;
    chk("rstld_ready_rel", dm_ready, 1);
    chk("rstld_no_done", dm_load_done, 0);
    chk("rstld_im_valid", im_valid, 0);

    // Back-to-back loads
    drive_dm(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    next(); #1;
    chk("b2b_first_done", dm_load_done, 1);
    next(); drive_dm(1'b1, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    chk("b2b_ready", dm_ready, 1);
`ifdef URV_MEM_ARB_RR_EN
    exp_lat = 3;
`else
    exp_lat = 2;
`endif
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      next(); drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      if (dm_load_done) begin
        lat = i;
        chk("b2b_data", dm_data_l, 32'hA5A5A5A5);
        break;
      end
    end
    chk("b2b_latency", lat, exp_lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/urv_mem_arbiter.md
Name: urv_mem_arbiter

Overview:
- Shares one single-port synchronous 32-bit RAM between the urv_cpu instruction-fetch port (im_*) and data port (dm_*).
- Diverts data accesses at or above IO_BASE to a simple I/O bus. This covers the console at 0x100000 and the test-complete register at 0x100004.
- Sits between urv_cpu and the RAM/peripherals in the ISA-testsuite bench and the SoC top.

Parameters:
- ADDR_WIDTH, 14, RAM word-address bits (RAM depth 2^ADDR_WIDTH words).
- IO_BASE, 32'h00100000, data byte addresses >= IO_BASE go to the I/O bus.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- im_addr_i  in  32  fetch byte address.
- im_data_o  out  32  fetched word.
- im_valid_o  out  1  im_data_o valid.
- dm_addr_i  in  32  data byte address.
- dm_data_s_i  in  32  store data.
- dm_data_select_i  in  4  store byte enables.
- dm_store_i  in  1  store request.
- dm_load_i  in  1  load request.
- dm_data_l_o  out  32  load data.
- dm_load_done_o  out  1  load complete pulse.
- dm_store_done_o  out  1  store complete pulse.
- dm_ready_o  out  1  arbiter can accept a data request.
- ram_addr_o  out  ADDR_WIDTH  RAM word address.
- ram_en_o  out  1  RAM access enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid 1 cycle after ram_en_o.
- io_rd_o  out  1  I/O read strobe.
- io_wr_o  out  1  I/O write strobe.
- io_addr_o  out  32  I/O byte address.
- io_wdata_o  out  32  I/O write data.
- io_sel_o  out  4  I/O byte enables.
- io_rdata_i  in  32  I/O read data.
- io_ready_i  in  1  I/O access complete.

Behaviour:
- Reset: while rst_i=1 all outputs are 0, the FSM is IDLE and any pending operation is dropped with no done pulse. dm_ready_o rises in the first cycle after rst_i falls.
- FSM states: IDLE, DPEND, IO_WAIT.
- Fetch is requested every cycle out of reset.
  - In IDLE with no data request, cycle N drives ram_en_o=1, ram_we_o=0, ram_addr_o=im_addr_i[ADDR_WIDTH+1:2].
  - In N+1: im_valid_o=1 and im_data_o=ram_rdata_i.
  - Back-to-back fetches give one word per cycle.
- Data request: dm_load_i or dm_store_i is sampled only when dm_ready_o=1.
  - Cycle N: register addr, data and select; drop dm_ready_o to 0 from N+1; FSM goes to DPEND.
  - If both dm_load_i and dm_store_i are asserted, the store wins.
- DPEND, RAM target, access issued in N+1:
  - Store: ram_we_o=dm_data_select, ram_wdata_o=data; dm_store_done_o=1 in N+1.
  - Load: ram_en_o=1; dm_load_done_o=1 in N+2 with dm_data_l_o=ram_rdata_i.
  - The FSM returns to IDLE after issue; dm_ready_o=1 again the cycle after the done pulse.
  - No fetch is issued in N+1, so im_valid_o=0 in N+2.
- DPEND, I/O target (addr >= IO_BASE, unsigned 32-bit compare):
  - Go to IO_WAIT and hold io_rd_o or io_wr_o plus address/data/select stable until io_ready_i=1.
  - Done pulse in the io_ready_i cycle; for loads dm_data_l_o=io_rdata_i.
  - Fetches continue in parallel during IO_WAIT.
- Address rules:
  - RAM addresses wrap modulo 2^ADDR_WIDTH words; upper bits are ignored except for the IO decode.
  - addr[1:0] is ignored.
  - io_addr_o carries the full byte address.
- dm_load_done_o and dm_store_done_o are single-cycle pulses and are never both 1.
- dm_load_i/dm_store_i asserted while dm_ready_o=0 are ignored.

Optional Feature:
- Macro: URV_MEM_ARB_RR_EN.
- Defined: round-robin. If the previous RAM grant was data, a newly captured data request waits one extra cycle while one fetch is granted. Load/store done latency rises by 1 cycle in that case only.
- Undefined: fixed priority, data always wins, latency exactly as in Behaviour.

Test Plan:
- Fetch stream: preload mem[0..3]=0x13,0x93,0x113,0x193; fetch 0x0,0x4,0x8,0xC on consecutive cycles -> im_valid_o=1 for 4 consecutive cycles with those words, each one cycle after its address.
- Store/load: store 0xDEADBEEF select=4'b0110 to 0x40 over old 0x11223344, then load 0x40 -> dm_store_done_o at N+1; dm_load_done_o at N+2 with 0x11ADBE44; im_valid_o low in the cycles after each data issue.
- Wrap: store 0xA5A5A5A5 to byte address 0x10000 with ADDR_WIDTH=14 -> ram_addr_o=0, mem[0]=0xA5A5A5A5.
- I/O: store 0x41 to 0x100000 with io_ready_i delayed 3 cycles -> io_wr_o held 4 cycles; dm_store_done_o in the io_ready_i cycle; fetches continue meanwhile; store to 0x100004 -> io_wr_o with io_addr_o=0x100004.
- Reset mid-load: assert rst_i in N+1 of a load -> no dm_load_done_o, all outputs 0 next cycle, dm_ready_o=1 the cycle after rst_i deasserts.
- URV_MEM_ARB_RR_EN: two back-to-back loads -> second load done one cycle later than without the macro, with one im_valid_o pulse in between.
